// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_ctrl
//  Description : Time-multiplexed scan controller for a common-anode
//                multi-digit 7-segment display sharing one combinational
//                hex-to-7-segment decoder. One digit is served per slot of
//                DIV clock cycles. Each slot opens with DEAD blanking cycles
//                (anti-ghosting). The digit's segment pattern is then
//                captured from the decoder and held for the remainder of
//                the slot. Display words are double-buffered and committed
//                only at frame boundaries, so a frame never mixes two words.
//
//  Parameters  : DIG_N - digits scanned (2..8)
//                DIV   - clock cycles per digit slot (>= 4)
//                DEAD  - blanking cycles at slot start (1..DIV-2)
//
//  Ports       : clk        in   system clock
//                rst        in   synchronous, active-high reset
//                load       in   write strobe for data_in
//                data_in    in   [31:0] display word, nibble k -> digit k
//                num_out    out  [3:0]  nibble presented to the decoder
//                dig_in     in   [7:0]  active-low pattern from the decoder
//                seg        out  [7:0]  active-low segment drive (registered)
//                com        out  [7:0]  active-low digit commons (registered)
//                load_ack   out  pulse: first cycle of a frame showing a
//                                newly committed word
//                frame_tick out  pulse: first cycle of every frame
//
//  Build macro : LED_LZ_BLANK_EN - when defined, leading zeros are blanked
//                (digit 0 is always shown).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module led_scan_ctrl #(
    parameter int DIG_N = 8,
    parameter int DIV   = 50000,
    parameter int DEAD  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data_in,
    output logic [3:0]  num_out,
    input  logic [7:0]  dig_in,
    output logic [7:0]  seg,
    output logic [7:0]  com,
    output logic        load_ack,
    output logic        frame_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_tick_w    = $clog2(DIV);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(DIV - 1);
    localparam logic [c_tick_w-1:0] c_dead      = c_tick_w'(DEAD);
    localparam logic [2:0]          c_idx_last  = 3'(DIG_N - 1);
    localparam logic [7:0]          c_blank     = 8'hFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_tick_w-1:0] r_tick;      // position inside the current slot
    logic [2:0]          r_idx;       // digit being served
    logic [31:0]         r_active;    // word currently displayed
    logic [31:0]         r_pend;      // word waiting for the next boundary
    logic                r_pend_v;    // r_pend holds an uncommitted word
    logic [3:0]          r_num;       // decoder input, stable for a slot
    logic [7:0]          r_seg;
    logic [7:0]          r_com;
    logic                r_blank;     // current digit suppressed (LZ blank)
    logic                r_ack_pend;  // a commit happened at the last boundary

    // ------------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------------
    logic                w_slot_end;
    logic                w_boundary;
    logic                w_commit;
    logic [c_tick_w-1:0] w_tick_nxt;
    logic [2:0]          w_idx_nxt;
    logic [31:0]         w_active_nxt;
    logic [3:0]          w_num_nxt;
    logic                w_blank_nxt;
    logic                w_dead_nxt;
    logic                w_capture;
    logic [7:0]          w_seg_nxt;
    logic [7:0]          w_com_nxt;

    // Slot and frame sequencing. Registered outputs are computed from the
    // *next* tick/idx so that seg/com line up with the tick value present in
    // the same cycle (reset state tick=0 is a DEAD cycle with both blank).
    always_comb begin
        w_slot_end   = (r_tick == c_tick_last);
        w_boundary   = w_slot_end && (r_idx == c_idx_last);
        w_commit     = w_boundary && r_pend_v;

        w_tick_nxt   = w_slot_end ? '0 : (r_tick + c_tick_w'(1));

        w_idx_nxt    = r_idx;
        if (w_boundary) begin
            w_idx_nxt = 3'd0;
        end else if (w_slot_end) begin
            w_idx_nxt = r_idx + 3'd1;
        end

        // The commit and the slot start happen on the same edge, so the
        // first digit of the new frame must already see the new word.
        w_active_nxt = w_commit ? r_pend : r_active;
        w_num_nxt    = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
    end

    // Leading-zero suppression decision, taken once per slot from the word
    // that will be displayed during that slot.
`ifdef LED_LZ_BLANK_EN
    function automatic logic lz_blank(input logic [31:0] word,
                                      input logic [2:0]  k);
        logic any_nz;
        any_nz = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if ((j < DIG_N) && (j >= int'(k)) && (word[4*j +: 4] != 4'd0)) begin
                any_nz = 1'b1;
            end
        end
        return (k != 3'd0) && !any_nz;
    endfunction

    assign w_blank_nxt = lz_blank(w_active_nxt, w_idx_nxt);
`else
    assign w_blank_nxt = 1'b0;
`endif

    // Segment / common drive for the coming cycle.
    always_comb begin
        w_dead_nxt = (w_tick_nxt < c_dead);
        // The edge leaving tick = DEAD-1 is the capture point: num_out has
        // been stable since slot start, giving the decoder DEAD cycles.
        w_capture  = (w_tick_nxt == c_dead);

        w_seg_nxt  = r_seg;
        w_com_nxt  = r_com;
        if (w_dead_nxt || r_blank) begin
            w_seg_nxt = c_blank;
            w_com_nxt = c_blank;
        end else begin
            // idx < DIG_N, so unused commons stay high automatically.
            w_com_nxt = ~(8'd1 << w_idx_nxt);
            if (w_capture) begin
                w_seg_nxt = dig_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick     <= '0;
            r_idx      <= 3'd0;
            r_active   <= 32'd0;
            r_pend     <= 32'd0;
            r_pend_v   <= 1'b0;
            r_num      <= 4'd0;
            r_seg      <= c_blank;
            r_com      <= c_blank;
            r_blank    <= 1'b0;
            r_ack_pend <= 1'b0;
        end else begin
            r_tick   <= w_tick_nxt;
            r_idx    <= w_idx_nxt;
            r_active <= w_active_nxt;

            // A load always lands in the pending buffer. On a boundary cycle
            // the commit above has already taken the old pending word, and
            // the new one stays pending for the next boundary.
            if (load) begin
                r_pend   <= data_in;
                r_pend_v <= 1'b1;
            end else if (w_commit) begin
                r_pend_v <= 1'b0;
            end

            if (w_slot_end) begin
                r_num   <= w_num_nxt;
                r_blank <= w_blank_nxt;
            end

            r_seg      <= w_seg_nxt;
            r_com      <= w_com_nxt;
            r_ack_pend <= w_commit;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign num_out    = r_num;
    assign seg        = r_seg;
    assign com        = r_com;

    // frame_tick is decoded from the counters rather than registered: the
    // counters already sit at tick=0/idx=0 while reset is held, and the pulse
    // has to appear on the very first cycle after reset is released. Gating
    // with rst keeps it low throughout reset.
    assign frame_tick = ~rst & (r_tick == '0) & (r_idx == 3'd0);
    assign load_ack   = frame_tick & r_ack_pend;

endmodule
`default_nettype wire
